// File: rtl/usb_packet_tx_pkg.sv
// Shared types and constants for the USB packet transmitter: bus levels,
// CRC modes, PID codes, CRC polynomials/init/residues and the tx FSM states.
package usb_packet_tx_pkg;

  typedef enum logic [1:0] {
    BUS_J   = 2'd0,
    BUS_K   = 2'd1,
    BUS_SE0 = 2'd2
  } bus_state_t;

  typedef enum logic [1:0] {
    CRC_NONE = 2'd0,
    CRC_5    = 2'd1,
    CRC_16   = 2'd2
  } crc_sel_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_PID,
    ST_PAYLOAD,
    ST_CRC,
    ST_EOP_SE0,
    ST_EOP_J
  } tx_state_t;

  localparam logic [3:0] PID_OUT   = 4'h1;
  localparam logic [3:0] PID_IN    = 4'h9;
  localparam logic [3:0] PID_SETUP = 4'hD;
  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = 4'hB;
  localparam logic [3:0] PID_ACK   = 4'h2;
  localparam logic [3:0] PID_NAK   = 4'hA;

  localparam logic [4:0]  CRC5_POLY     = 5'h05;
  localparam logic [4:0]  CRC5_INIT     = 5'h1F;
  localparam logic [4:0]  CRC5_RESIDUE  = 5'h0C;
  localparam logic [15:0] CRC16_POLY    = 16'h8005;
  localparam logic [15:0] CRC16_INIT    = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUE = 16'h800D;

  // Encoding 3 is reserved and falls back to no CRC.
  function automatic crc_sel_t decode_crc_sel(input logic [1:0] raw);
    case (raw)
      2'd1:    return CRC_5;
      2'd2:    return CRC_16;
      default: return CRC_NONE;
    endcase
  endfunction

  function automatic logic [4:0] crc_len(input crc_sel_t sel);
    case (sel)
      CRC_5:   return 5'd5;
      CRC_16:  return 5'd16;
      default: return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/usb_packet_tx_if.sv
// Request/bus bundle between the host transaction tasks and the packet
// transmitter; master = requester, slave = transmitter.
interface usb_packet_tx_if #(
  parameter int MAX_PAYLOAD_BYTES = 8
);
  localparam int PAYLOAD_W = 8 * MAX_PAYLOAD_BYTES;
  localparam int PB_W      = $clog2(PAYLOAD_W + 1);

  logic                 start;
  logic [3:0]           pid;
  logic [1:0]           crc_sel;
  logic [PAYLOAD_W-1:0] payload;
  logic [PB_W-1:0]      payload_bits;
  logic                 busy;
  logic                 done;
  logic                 dp;
  logic                 dm;
  logic                 oe;

  modport master (
    output start, pid, crc_sel, payload, payload_bits,
    input  busy, done, dp, dm, oe
  );

  modport slave (
    input  start, pid, crc_sel, payload, payload_bits,
    output busy, done, dp, dm, oe
  );

endinterface

// File: rtl/usb_packet_tx_crc_serial.sv
// Bit-serial CRC generator (shift-register form, MSB-out feedback).
// Clear loads INIT; each enabled cycle folds one data bit in.
module usb_crc_serial #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] POLY  = 16'h8005,
  parameter logic [WIDTH-1:0] INIT  = 16'hFFFF
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             din,
  output logic [WIDTH-1:0] rem
);

  logic [WIDTH-1:0] crc_q, crc_d;
  logic             fb;

  always_comb begin
    crc_d = crc_q;
    fb    = din ^ crc_q[WIDTH-1];
    if (clear)
      crc_d = INIT;
    else if (shift_en)
      crc_d = {crc_q[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) crc_q <= INIT;
    else          crc_q <= crc_d;
  end

  assign rem = crc_q;

endmodule

// File: rtl/usb_packet_tx.sv
// Serial USB packet engine: SYNC, PID, payload, CRC5/CRC16, EOP with bit
// stuffing and NRZI, one bus bit per clock.
module usb_packet_tx
  import usb_packet_tx_pkg::*;
#(
  parameter int         MAX_PAYLOAD_BYTES = 8,
  parameter int         STUFF_RUN         = 6,
  parameter logic [7:0] SYNC_PATTERN      = 8'b1000_0000
) (
  input  logic         clock,
  input  logic         reset_n,
  usb_packet_tx_if.slave bus
);

  localparam int PAYLOAD_W = 8 * MAX_PAYLOAD_BYTES;
  localparam int PB_W      = $clog2(PAYLOAD_W + 1);
  localparam int CNT_W     = (PB_W > 5) ? PB_W : 5;
  localparam int ONES_W    = $clog2(STUFF_RUN + 1);

  tx_state_t            state_q, state_d, next_field;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ONES_W-1:0]    ones_q, ones_d;
  logic                 level_q, level_d;
  logic                 done_q, done_d;
  logic [3:0]           pid_q, pid_d;
  crc_sel_t             crc_sel_q, crc_sel_d;
  logic [PAYLOAD_W-1:0] payload_q, payload_d;
  logic [PB_W-1:0]      plen_q, plen_d;

  logic                 crc_clear, crc_shift;
  logic [4:0]           crc5_rem;
  logic [15:0]          crc16_rem;
  logic                 raw_bit, stuff_now, last_bit, stream_bit, line_j;
  logic [CNT_W-1:0]     field_len;
  logic [7:0]           sync_sh, pid_sh;
  logic [PAYLOAD_W-1:0] pay_sh;
  logic [4:0]           crc5_sh;
  logic [15:0]          crc16_sh;
  bus_state_t           bus_lvl;

  usb_crc_serial #(.WIDTH(5), .POLY(CRC5_POLY), .INIT(CRC5_INIT)) u_crc5 (
    .clock(clock), .reset_n(reset_n), .clear(crc_clear),
    .shift_en(crc_shift), .din(raw_bit), .rem(crc5_rem)
  );

  usb_crc_serial #(.WIDTH(16), .POLY(CRC16_POLY), .INIT(CRC16_INIT)) u_crc16 (
    .clock(clock), .reset_n(reset_n), .clear(crc_clear),
    .shift_en(crc_shift), .din(raw_bit), .rem(crc16_rem)
  );

  // Raw (pre-stuffing) bit of the current field and that field's length.
  always_comb begin
    sync_sh   = SYNC_PATTERN >> cnt_q;
    pid_sh    = {~pid_q, pid_q} >> cnt_q;
    pay_sh    = payload_q >> cnt_q;
    crc5_sh   = crc5_rem << cnt_q;
    crc16_sh  = crc16_rem << cnt_q;
    raw_bit   = 1'b0;
    field_len = CNT_W'(8);
    case (state_q)
      ST_SYNC:    raw_bit = sync_sh[0];
      ST_PID:     raw_bit = pid_sh[0];
      ST_PAYLOAD: begin
        raw_bit   = pay_sh[0];
        field_len = CNT_W'(plen_q);
      end
      ST_CRC: begin
        raw_bit   = (crc_sel_q == CRC_5) ? ~crc5_sh[4] : ~crc16_sh[15];
        field_len = CNT_W'(crc_len(crc_sel_q));
      end
      default: ;
    endcase
  end

  assign last_bit = ((cnt_q + CNT_W'(1)) == field_len);

  // A pending stuff bit also preempts the first EOP cycle when the run ends on the last CRC bit.
  assign stuff_now = (ones_q == ONES_W'(STUFF_RUN)) &&
                     (state_q inside {ST_SYNC, ST_PID, ST_PAYLOAD, ST_CRC, ST_EOP_SE0});

  always_comb begin
    next_field = ST_EOP_SE0;
    case (state_q)
      ST_SYNC: next_field = ST_PID;
      ST_PID: begin
        if (plen_q != '0)                next_field = ST_PAYLOAD;
        else if (crc_sel_q != CRC_NONE)  next_field = ST_CRC;
      end
      ST_PAYLOAD: if (crc_sel_q != CRC_NONE) next_field = ST_CRC;
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ones_d    = ones_q;
    level_d   = level_q;
    done_d    = 1'b0;
    pid_d     = pid_q;
    crc_sel_d = crc_sel_q;
    payload_d = payload_q;
    plen_d    = plen_q;
    crc_clear = 1'b0;
    crc_shift = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d   = ST_SYNC;
          cnt_d     = '0;
          ones_d    = '0;
          level_d   = 1'b1;
          pid_d     = bus.pid;
          crc_sel_d = decode_crc_sel(bus.crc_sel);
          payload_d = bus.payload;
          plen_d    = (bus.payload_bits > PB_W'(PAYLOAD_W)) ? PB_W'(PAYLOAD_W)
                                                             : bus.payload_bits;
          crc_clear = 1'b1;
        end
      end
      ST_SYNC, ST_PID, ST_PAYLOAD, ST_CRC: begin
        if (stuff_now) begin
          ones_d  = '0;
          level_d = ~level_q;
        end else begin
          ones_d    = raw_bit ? ones_q + ONES_W'(1) : '0;
          level_d   = raw_bit ? level_q : ~level_q;
          crc_shift = (state_q == ST_PAYLOAD);
          if (last_bit) begin
            cnt_d   = '0;
            state_d = next_field;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_EOP_SE0: begin
        ones_d = '0;
        if (stuff_now) begin
          level_d = ~level_q;
        end else if (cnt_q == CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = ST_EOP_J;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_EOP_J: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      ones_q    <= '0;
      level_q   <= 1'b1;
      done_q    <= 1'b0;
      pid_q     <= '0;
      crc_sel_q <= CRC_NONE;
      payload_q <= '0;
      plen_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ones_q    <= ones_d;
      level_q   <= level_d;
      done_q    <= done_d;
      pid_q     <= pid_d;
      crc_sel_q <= crc_sel_d;
      payload_q <= payload_d;
      plen_q    <= plen_d;
    end
  end

  // NRZI: a stream 0 flips the line, a 1 holds it; level_q is the level before this bit.
  assign stream_bit = stuff_now ? 1'b0 : raw_bit;
  assign line_j     = stream_bit ? level_q : ~level_q;

  always_comb begin
    bus_lvl = BUS_J;
    case (state_q)
      ST_SYNC, ST_PID, ST_PAYLOAD, ST_CRC: bus_lvl = line_j ? BUS_J : BUS_K;
      ST_EOP_SE0: bus_lvl = stuff_now ? (line_j ? BUS_J : BUS_K) : BUS_SE0;
      default:    bus_lvl = BUS_J;
    endcase
  end

  assign bus.dp   = (bus_lvl == BUS_J);
  assign bus.dm   = (bus_lvl == BUS_K);
  assign bus.oe   = (state_q != ST_IDLE);
  assign bus.busy = (state_q != ST_IDLE);
  assign bus.done = done_q;

endmodule

// File: tb/tb_usb_packet_tx.sv
// Directed + randomized bench for usb_packet_tx: a queue-based packet model
// gives the expected wire per cycle; the observed wire is also decoded back.
module tb_usb_packet_tx;
  import usb_packet_tx_pkg::*;

  localparam int MPB = 8;
  localparam int PW  = 8 * MPB;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  usb_packet_tx_if #(.MAX_PAYLOAD_BYTES(MPB)) bus_if ();

  usb_packet_tx #(
    .MAX_PAYLOAD_BYTES(MPB), .STUFF_RUN(6), .SYNC_PATTERN(8'b1000_0000)
  ) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus_if.slave)
  );

  always #5 clock = ~clock;

  bit         m_raw[$];
  logic [1:0] m_wire[$];
  int         m_stuff, m_clen;
  bit         o_raw[$];
  int         o_stuff, o_maxrun;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int crc_of(input bit b[$], input int w, input int poly, input int init);
    int c, mask, fb;
    c = init;
    mask = (1 << w) - 1;
    foreach (b[i]) begin
      fb = b[i] ^ ((c >> (w - 1)) & 1);
      c  = (c << 1) & mask;
      if (fb != 0) c = c ^ poly;
    end
    return c;
  endfunction

  function automatic logic [127:0] pack(input bit q[$]);
    logic [127:0] v = '0;
    foreach (q[i]) if (i < 128) v[i] = q[i];
    return v;
  endfunction

  // Packet as the wire must carry it, built field by field from the rules.
  task automatic build_model(input logic [3:0] p, input logic [1:0] cs,
                             input logic [PW-1:0] pl, input int pbits);
    logic [7:0] sync = 8'b1000_0000;
    logic [7:0] pidb;
    bit pay[$];
    bit strm[$];
    int pb, rem, ones;
    bit lvl;
    m_raw.delete(); m_wire.delete();
    pidb = {~p, p};
    for (int i = 0; i < 8; i++) m_raw.push_back(sync[i]);
    for (int i = 0; i < 8; i++) m_raw.push_back(pidb[i]);
    pb = (pbits > PW) ? PW : pbits;
    for (int i = 0; i < pb; i++) begin
      m_raw.push_back(pl[i]);
      pay.push_back(pl[i]);
    end
    m_clen = (cs == 2'd1) ? 5 : (cs == 2'd2) ? 16 : 0;
    if (m_clen == 5)  rem = crc_of(pay, 5, 'h05, 'h1F);
    else              rem = crc_of(pay, 16, 'h8005, 'hFFFF);
    for (int i = m_clen - 1; i >= 0; i--) m_raw.push_back(((rem >> i) & 1) == 0);
    m_stuff = 0;
    ones = 0;
    foreach (m_raw[i]) begin
      strm.push_back(m_raw[i]);
      ones = m_raw[i] ? ones + 1 : 0;
      if (ones == 6) begin
        strm.push_back(1'b0);
        ones = 0;
        m_stuff++;
      end
    end
    lvl = 1'b1;
    foreach (strm[i]) begin
      if (!strm[i]) lvl = !lvl;
      m_wire.push_back({lvl, !lvl});
    end
    m_wire.push_back(2'b00);
    m_wire.push_back(2'b00);
    m_wire.push_back(2'b10);
  endtask

  // Starts in the cycle after the accepting edge; returns at the done cycle's sample point.
  task automatic check_packet(input string tag);
    logic [1:0] lv[$];
    int L, ones, run, res;
    bit prev, b;
    bit crcbits[$];
    L = m_wire.size();
    for (int k = 0; k < L; k++) begin
      @(negedge clock);
      chk($sformatf("%s_cyc%0d", tag, k),
          {bus_if.oe, bus_if.busy, bus_if.done, bus_if.dp, bus_if.dm},
          {3'b110, m_wire[k]});
      if (k < L - 3) lv.push_back({bus_if.dp, bus_if.dm});
    end
    @(negedge clock);
    chk({tag, "_done"}, {bus_if.oe, bus_if.busy, bus_if.done, bus_if.dp, bus_if.dm}, 5'b00110);
    o_raw.delete();
    o_stuff = 0; o_maxrun = 0; run = 0; ones = 0;
    prev = 1'b1;
    foreach (lv[k]) begin
      b = (lv[k][1] == prev);
      run = (k > 0 && lv[k][1] == prev) ? run + 1 : 1;
      if (run > o_maxrun) o_maxrun = run;
      prev = lv[k][1];
      if (ones == 6) begin
        o_stuff++;
        ones = 0;
      end else begin
        o_raw.push_back(b);
        ones = b ? ones + 1 : 0;
      end
    end
    chk({tag, "_stuffcnt"}, o_stuff, m_stuff);
    chk({tag, "_rawlen"}, o_raw.size(), m_raw.size());
    chk({tag, "_rawbits"}, pack(o_raw), pack(m_raw));
    if (m_clen != 0) begin
      for (int i = 16; i < o_raw.size(); i++) crcbits.push_back(o_raw[i]);
      if (m_clen == 5) begin
        res = crc_of(crcbits, 5, 'h05, 'h1F);
        chk({tag, "_crc5res"}, res, 5'b01100);
      end else begin
        res = crc_of(crcbits, 16, 'h8005, 'hFFFF);
        chk({tag, "_crc16res"}, res, 16'h800D);
      end
    end
  endtask

  task automatic drive(input logic [3:0] p, input logic [1:0] cs,
                       input logic [PW-1:0] pl, input int pbits);
    bus_if.pid          = p;
    bus_if.crc_sel      = cs;
    bus_if.payload      = pl;
    bus_if.payload_bits = 7'(pbits);
  endtask

  task automatic send(input string tag, input logic [3:0] p, input logic [1:0] cs,
                      input logic [PW-1:0] pl, input int pbits);
    build_model(p, cs, pl, pbits);
    @(negedge clock);
    drive(p, cs, pl, pbits);
    bus_if.start = 1'b1;
    @(posedge clock);
    #1 bus_if.start = 1'b0;
    check_packet(tag);
    @(negedge clock);
    chk({tag, "_after"}, {bus_if.done, bus_if.oe, bus_if.busy}, 3'b000);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PW-1:0] pl;
    bus_if.start = 1'b0;
    drive(4'h0, 2'd0, '0, 0);

    repeat (2) @(negedge clock);
    chk("reset_outputs", {bus_if.oe, bus_if.dp, bus_if.dm, bus_if.busy, bus_if.done}, 5'b01000);
    reset_n = 1'b1;
    @(negedge clock);
    chk("idle_outputs", {bus_if.oe, bus_if.dp, bus_if.dm, bus_if.busy, bus_if.done}, 5'b01000);

    send("ack", PID_ACK, 2'd0, '0, 0);
    send("token", PID_OUT, 2'd1, {{(PW-11){1'b0}}, 4'h4, 7'h05}, 11);
    send("data0_zlp", PID_DATA0, 2'd2, '0, 0);

    send("ff64", PID_DATA1, 2'd2, '1, 64);
    chk("ff64_maxrun_le7", o_maxrun <= 7, 1'b1);

    // Back-to-back: start held through packet A; inputs changed mid-packet become packet B.
    build_model(PID_SETUP, 2'd1, {{(PW-11){1'b0}}, 11'h3A5}, 11);
    @(negedge clock);
    drive(PID_SETUP, 2'd1, {{(PW-11){1'b0}}, 11'h3A5}, 11);
    bus_if.start = 1'b1;
    @(posedge clock);
    pl = {$urandom, $urandom};
    #1 drive(PID_DATA1, 2'd2, pl, 24);
    check_packet("b2bA");
    build_model(PID_DATA1, 2'd2, pl, 24);
    @(posedge clock);
    #1 bus_if.start = 1'b0;
    check_packet("b2bB");
    @(negedge clock);
    chk("b2bB_after", {bus_if.done, bus_if.oe}, 2'b00);

    for (int r = 0; r < 6; r++) begin
      pl = {$urandom, $urandom};
      send($sformatf("rand%0d", r), 4'($urandom), 2'($urandom_range(0, 3)), pl,
           (r == 0) ? 100 : int'($urandom_range(0, 80)));
    end

    // Reset dropped while the payload is on the wire.
    pl = {$urandom, $urandom};
    @(negedge clock);
    drive(PID_DATA0, 2'd2, pl, 32);
    bus_if.start = 1'b1;
    @(posedge clock);
    #1 bus_if.start = 1'b0;
    repeat (20) @(negedge clock);
    #2 reset_n = 1'b0;
    #1 chk("rst_mid_async", {bus_if.oe, bus_if.dp, bus_if.dm, bus_if.busy, bus_if.done}, 5'b01000);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk($sformatf("rst_hold%0d", k),
          {bus_if.oe, bus_if.dp, bus_if.dm, bus_if.busy, bus_if.done}, 5'b01000);
    end
    reset_n = 1'b1;
    send("post_reset", PID_DATA0, 2'd2, pl, 32);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
